memory_interface: RTL and testbench
===================================

// Module: memory_interface
// PURPOSE
//  Memory-side controller for the MDR/MAR datapath: turns a one-cycle read or write request into a
//  strobed, wait-stated access to synchronous RAM.
//  Read data is returned on Mdatain, which feeds the MDR input mux alongside BusMuxOut.
//  Write data is taken from the MDR.
//  Sits between the CPU control unit and the 512-word memory array.
// PARAMETERS
//  DATA_WIDTH   32  width of data words (MDR, Mdatain, RAM)
//  ADDR_WIDTH   9   word address width (from MAR)
//  WAIT_STATES  2   extra cycles the strobe is held beyond the first (0..15 legal)
// PORTS
//  clk        in   1           system clock, rising edge
//  clr_n      in   1           asynchronous active-low reset
//  read_req   in   1           request a read; sampled only in IDLE
//  write_req  in   1           request a write; sampled only in IDLE
//  mar_addr   in   ADDR_WIDTH  address from MAR; latched with the request
//  mdr_data   in   DATA_WIDTH  write data from MDR; latched with a write request
//  Mdatain    out  DATA_WIDTH  last read word, to MDR input mux
//  busy       out  1           access in progress (RD_WAIT/WR_WAIT)
//  mem_done   out  1           one-cycle completion pulse
//  req_err    out  1           one-cycle pulse: read_req and write_req both high in IDLE
//  mem_addr   out  ADDR_WIDTH  RAM address (latched copy)
//  mem_wdata  out  DATA_WIDTH  RAM write data (latched copy)
//  mem_re     out  1           RAM read strobe
//  mem_we     out  1           RAM write strobe
//  mem_rdata  in   DATA_WIDTH  RAM read data; valid while mem_re is high
// BEHAVIOUR
//  Reset (clr_n low, async)
//   - state=IDLE; all outputs 0, including Mdatain, latched addr/data and the wait counter.
//   - Mid-access reset: strobes drop immediately and the access is abandoned without a mem_done.
//  FSM: IDLE -> RD_WAIT | WR_WAIT -> DONE -> IDLE
//  - IDLE:
//    - read_req=1 at an edge: latch mar_addr, cnt<=WAIT_STATES, go to RD_WAIT.
//    - write_req=1 alone: also latch mdr_data, go to WR_WAIT.
//    - Both high: read wins, write dropped, req_err pulses in the following cycle.
//  - RD_WAIT/WR_WAIT:
//    - mem_re or mem_we=1 and busy=1; mem_addr/mem_wdata are stable from the latches.
//    - Each edge: cnt!=0 -> cnt--.
//    - cnt==0 -> go to DONE; in RD_WAIT, Mdatain<=mem_rdata on that same edge.
//  - DONE: mem_done=1 for exactly one cycle, strobes 0, busy 0, then IDLE.
//  - Requests are ignored outside IDLE, including during DONE. Requesters hold or reissue.
//  - Latency: request edge to the mem_done cycle = WAIT_STATES+2 cycles.
//    Strobe width = WAIT_STATES+1 cycles. Back-to-back throughput is one access per WAIT_STATES+3 cycles.
//  - Mdatain is held until the next completed read; writes never change it.
//  - Strobes are registered (state decode, no combinational path from req). mem_re and mem_we are never both 1.
//  - WAIT_STATES=0: single-cycle strobe; the counter is unused but legal.
// STRUCTURE
//  - Shared package (cpu_pkg): DATA_WIDTH/ADDR_WIDTH constants and the mem_state_t enum
//    {IDLE, RD_WAIT, WR_WAIT, DONE} as 2-bit localparams.
//  - Single module; the wait counter is inline. No sub-module is warranted.
//  - The bench uses a behavioural RAM model that responds combinationally to mem_addr when mem_re=1.
// TESTING
//  1. Reset:
//     - Drive clr_n=0 mid-simulation during RD_WAIT.
//     - Expect mem_re=0, busy=0 and Mdatain=0 immediately; no mem_done afterwards.
//  2. Read:
//     - Preload RAM[9'h010]=32'hDEADBEEF; pulse read_req with mar_addr=9'h010 (WAIT_STATES=2).
//     - Expect mem_re high 3 cycles, mem_done in cycle 4 after the request edge, Mdatain=32'hDEADBEEF.
//  3. Write then read:
//     - Write mdr_data=32'd16 to 9'h020, expect mem_we high 3 cycles with mem_wdata=16; Mdatain unchanged.
//     - Then read 9'h020, expect Mdatain=32'd16.
//  4. Simultaneous requests:
//     - read_req=write_req=1 at 9'h030 (RAM=32'd32).
//     - Expect req_err pulse, read performed, Mdatain=32'd32, no mem_we.
//  5. Ignored request:
//     - Assert write_req during busy and during DONE.
//     - Expect no second access; mem_we never asserted after the DONE cycle.
//  6. WAIT_STATES=0 build:
//     - Read 9'h000=32'h1.
//     - Expect a 1-cycle mem_re and mem_done 2 cycles after the request edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the memory-controller state encoding.
package cpu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 9;
    // Wide enough for the full legal wait-state range (0..15).
    localparam int CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } mem_state_t;

endpackage

// File: rtl/memory_interface.sv
// Memory-side controller between the CPU control unit and synchronous RAM.
// Converts a one-cycle read/write request into a strobed access held for
// WAIT_STATES+1 cycles, followed by a one-cycle completion pulse.
module memory_interface
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH  = cpu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH  = cpu_pkg::ADDR_WIDTH,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  read_req,
    input  logic                  write_req,
    input  logic [ADDR_WIDTH-1:0] mar_addr,
    input  logic [DATA_WIDTH-1:0] mdr_data,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  busy,
    output logic                  mem_done,
    output logic                  req_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(WAIT_STATES);

    mem_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] mdat_q, mdat_d;
    logic                  err_q, err_d;
    logic                  re_q, re_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Next-state, latch and wait-counter logic; outputs decoded from next state
    // so strobes come straight from flops with no path from the request pins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mdat_d  = mdat_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (read_req) begin
                    // Read wins a collision; the write is dropped and flagged.
                    addr_d  = mar_addr;
                    cnt_d   = CNT_LOAD;
                    state_d = RD_WAIT;
                    err_d   = write_req;
                end else if (write_req) begin
                    addr_d  = mar_addr;
                    wdata_d = mdr_data;
                    cnt_d   = CNT_LOAD;
                    state_d = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    // RAM data is valid while the read strobe is up.
                    mdat_d  = mem_rdata;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        re_d   = (state_d == RD_WAIT);
        we_d   = (state_d == WR_WAIT);
        busy_d = re_d | we_d;
        done_d = (state_d == DONE);
    end

    // State and registered outputs; async reset abandons any access in flight.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mdat_q  <= '0;
            err_q   <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mdat_q  <= mdat_d;
            err_q   <= err_d;
            re_q    <= re_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Mdatain   = mdat_q;
    assign busy      = busy_q;
    assign mem_done  = done_q;
    assign req_err   = err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_re    = re_q;
    assign mem_we    = we_q;

endmodule

// File: tb/tb_memory_interface.sv
// Bench for memory_interface: a WAIT_STATES=2 instance (index 0) and a
// WAIT_STATES=0 instance (index 1), each with its own behavioural RAM.
module tb_memory_interface;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        rd_r [2];
    logic        wr_r [2];
    logic [8:0]  addr = '0;
    logic [31:0] wdata = '0;

    logic [1:0]  re_w, we_w, done_w, err_w, busy_w;
    logic [31:0] mdat_w [2];
    logic [31:0] mwd_w [2];
    logic [31:0] rdata_w [2];
    logic [8:0]  maddr_w [2];

    logic [31:0] ram_a [512];
    logic [31:0] ram_b [512];
    logic        pl_en [2];
    logic [8:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_interface #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .clr_n(clr_n), .read_req(rd_r[0]), .write_req(wr_r[0]),
        .mar_addr(addr), .mdr_data(wdata), .Mdatain(mdat_w[0]), .busy(busy_w[0]),
        .mem_done(done_w[0]), .req_err(err_w[0]), .mem_addr(maddr_w[0]),
        .mem_wdata(mwd_w[0]), .mem_re(re_w[0]), .mem_we(we_w[0]), .mem_rdata(rdata_w[0])
    );

    memory_interface #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .clr_n(clr_n), .read_req(rd_r[1]), .write_req(wr_r[1]),
        .mar_addr(addr), .mdr_data(wdata), .Mdatain(mdat_w[1]), .busy(busy_w[1]),
        .mem_done(done_w[1]), .req_err(err_w[1]), .mem_addr(maddr_w[1]),
        .mem_wdata(mwd_w[1]), .mem_re(re_w[1]), .mem_we(we_w[1]), .mem_rdata(rdata_w[1])
    );

    // Behavioural RAMs: combinational read under mem_re, write on the clock.
    assign rdata_w[0] = re_w[0] ? ram_a[maddr_w[0]] : 32'h0;
    assign rdata_w[1] = re_w[1] ? ram_b[maddr_w[1]] : 32'h0;

    always @(posedge clk) begin
        if (we_w[0]) ram_a[maddr_w[0]] <= mwd_w[0];
        else if (pl_en[0]) ram_a[pl_addr] <= pl_data;
    end

    always @(posedge clk) begin
        if (we_w[1]) ram_b[maddr_w[1]] <= mwd_w[1];
        else if (pl_en[1]) ram_b[pl_addr] <= pl_data;
    end

    typedef struct {
        int          sel;
        logic        rd;
        logic        wr;
        logic [8:0]  a;
        logic [31:0] d;
        logic [31:0] exp_mdat;
        int          exp_re;
        int          exp_we;
        int          exp_done;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input int s, input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en[s] = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en[s] = 1'b0;
    endtask

    // Issue one request and watch until mem_done (bounded), then step into IDLE.
    task automatic access(input int s, input logic rd, input logic wr,
                          input logic [8:0] a, input logic [31:0] d,
                          output int nre, output int nwe, output int dcyc,
                          output logic err, output logic bad_bus);
        @(negedge clk);
        rd_r[s] = rd; wr_r[s] = wr; addr = a; wdata = d;
        @(posedge clk); #1;
        rd_r[s] = 1'b0; wr_r[s] = 1'b0;
        nre = 0; nwe = 0; dcyc = -1; err = 1'b0; bad_bus = 1'b0;
        for (int c = 1; c <= 20 && dcyc < 0; c++) begin
            if (re_w[s]) nre++;
            if (we_w[s]) nwe++;
            if (re_w[s] && we_w[s]) bad_bus = 1'b1;
            if ((re_w[s] || we_w[s]) && maddr_w[s] != a) bad_bus = 1'b1;
            if (we_w[s] && mwd_w[s] != d) bad_bus = 1'b1;
            if (err_w[s]) err = 1'b1;
            if (done_w[s]) dcyc = c;
            if (dcyc < 0) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vt [5];
        int nre, nwe, dcyc, ndone;
        logic err, bad;

        rd_r[0] = 0; rd_r[1] = 0; wr_r[0] = 0; wr_r[1] = 0;
        pl_en[0] = 0; pl_en[1] = 0;
        for (int i = 0; i < 512; i++) begin ram_a[i] = '0; ram_b[i] = '0; end

        // Reset state of both instances
        #12;
        chk("rst_re",   {30'b0, re_w},   32'h0);
        chk("rst_we",   {30'b0, we_w},   32'h0);
        chk("rst_busy", {30'b0, busy_w}, 32'h0);
        chk("rst_done", {30'b0, done_w}, 32'h0);
        chk("rst_err",  {30'b0, err_w},  32'h0);
        chk("rst_mdat", mdat_w[0] | mdat_w[1], 32'h0);
        chk("rst_addr", {23'b0, maddr_w[0] | maddr_w[1]}, 32'h0);
        chk("rst_wd",   mwd_w[0] | mwd_w[1], 32'h0);
        @(negedge clk); clr_n = 1'b1;

        preload(0, 9'h010, 32'hDEADBEEF);
        preload(0, 9'h030, 32'd32);
        preload(1, 9'h000, 32'h1);

        vt[0] = '{0, 1'b1, 1'b0, 9'h010, 32'h0,  32'hDEADBEEF, 3, 0, 4, 1'b0};
        vt[1] = '{0, 1'b0, 1'b1, 9'h020, 32'd16, 32'hDEADBEEF, 0, 3, 4, 1'b0};
        vt[2] = '{0, 1'b1, 1'b0, 9'h020, 32'h0,  32'd16,       3, 0, 4, 1'b0};
        vt[3] = '{0, 1'b1, 1'b1, 9'h030, 32'h77, 32'd32,       3, 0, 4, 1'b1};
        vt[4] = '{1, 1'b1, 1'b0, 9'h000, 32'h0,  32'h1,        1, 0, 2, 1'b0};

        for (int i = 0; i < 5; i++) begin
            access(vt[i].sel, vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, nre, nwe, dcyc, err, bad);
            chk($sformatf("v%0d_mdat", i), mdat_w[vt[i].sel], vt[i].exp_mdat);
            chk($sformatf("v%0d_re_cycles", i), nre, vt[i].exp_re);
            chk($sformatf("v%0d_we_cycles", i), nwe, vt[i].exp_we);
            chk($sformatf("v%0d_done_cycle", i), dcyc, vt[i].exp_done);
            chk($sformatf("v%0d_req_err", i), {31'b0, err}, {31'b0, vt[i].exp_err});
            chk($sformatf("v%0d_bus", i), {31'b0, bad}, 32'h0);
        end
        chk("ram_020", ram_a[9'h020], 32'd16);

        // Requests during busy and DONE are ignored
        @(negedge clk);
        wr_r[0] = 1'b1; addr = 9'h040; wdata = 32'h55;
        @(posedge clk); #1;
        wr_r[0] = 1'b0;
        @(posedge clk); #1;
        wr_r[0] = 1'b1; addr = 9'h050; wdata = 32'hAA;
        nwe = 1; dcyc = -1; bad = 1'b0;
        for (int c = 2; c <= 20 && dcyc < 0; c++) begin
            if (we_w[0]) nwe++;
            if (we_w[0] && (maddr_w[0] != 9'h040 || mwd_w[0] != 32'h55)) bad = 1'b1;
            if (done_w[0]) dcyc = c;
            if (dcyc < 0) begin @(posedge clk); #1; end
        end
        chk("ign_done_cycle", dcyc, 4);
        chk("ign_we_cycles", nwe, 3);
        chk("ign_latched", {31'b0, bad}, 32'h0);
        @(posedge clk); #1;
        wr_r[0] = 1'b0;
        nwe = 0; ndone = 0;
        for (int c = 0; c < 8; c++) begin
            if (we_w[0] || busy_w[0]) nwe++;
            if (done_w[0]) ndone++;
            @(posedge clk); #1;
        end
        chk("ign_we_after", nwe, 0);
        chk("ign_done_after", ndone, 0);
        chk("ign_ram_040", ram_a[9'h040], 32'h55);
        chk("ign_ram_050", ram_a[9'h050], 32'h0);
        chk("ign_mdat_kept", mdat_w[0], 32'd32);

        // Asynchronous reset in the middle of a read
        @(negedge clk);
        rd_r[0] = 1'b1; addr = 9'h010;
        @(posedge clk); #1;
        rd_r[0] = 1'b0;
        @(posedge clk); #1;
        chk("mid_re_before", {31'b0, re_w[0]}, 32'h1);
        #2 clr_n = 1'b0;
        #1;
        chk("mid_re",   {31'b0, re_w[0]},   32'h0);
        chk("mid_busy", {31'b0, busy_w[0]}, 32'h0);
        chk("mid_mdat", mdat_w[0], 32'h0);
        @(negedge clk); clr_n = 1'b1;
        nre = 0; ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (re_w[0]) nre++;
            if (done_w[0]) ndone++;
        end
        chk("mid_no_done", ndone, 0);
        chk("mid_no_re", nre, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
